// File: rtl/assist_curr_gen.sv
// Pedal-assist target current generator: torque x assist level x incline/cadence
// product, scaled and saturated, then slew-limited toward the motor current target.
module assist_curr_gen #(
    parameter int TORQUE_W   = 12,
    parameter int CAD_W      = 5,
    parameter int INCL_W     = 13,
    parameter int SCALE_W    = 3,
    parameter int OUT_W      = 12,
    parameter int TORQUE_MIN = 'h380,
    parameter int SHIFT      = 15,
    parameter int RISE_STEP  = 64,
    parameter int FALL_STEP  = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_vld,
    input  logic [TORQUE_W-1:0]      avg_torque,
    input  logic [CAD_W-1:0]         cadence,
    input  logic                     not_pedaling,
    input  logic signed [INCL_W-1:0] incline,
    input  logic [SCALE_W-1:0]       scale,
    input  logic                     brake,
    output logic [OUT_W-1:0]         target_curr,
    output logic                     out_vld,
    output logic                     sat_flag
);

    localparam int P1_W = TORQUE_W + SCALE_W;
    localparam int P2_W = 9 + CAD_W + 1;
    localparam int P3_W = P1_W + P2_W;

    localparam logic [TORQUE_W-1:0]      TMIN    = TORQUE_W'(TORQUE_MIN);
    localparam logic signed [INCL_W-1:0] INCL_HI = INCL_W'(511);
    localparam logic signed [INCL_W-1:0] INCL_LO = INCL_W'(-512);
    localparam logic [CAD_W:0]           CAD_OFS = (CAD_W+1)'(32);
    localparam logic [P3_W-1:0]          OUT_MAX = P3_W'((2**OUT_W) - 1);
    localparam logic [OUT_W:0]           RISE_X  = (OUT_W+1)'(RISE_STEP);
    localparam logic [OUT_W:0]           FALL_X  = (OUT_W+1)'(FALL_STEP);

    logic [9:0]          incline_sat;
    logic [10:0]         incline_sum;
    logic [8:0]          incline_lim;
    logic [CAD_W:0]      cadence_factor;
    logic [TORQUE_W-1:0] torque_pos;

    logic [P1_W-1:0]  p1;
    logic [P2_W-1:0]  p2;
    logic [P3_W-1:0]  p3;
    logic [P3_W-1:0]  p3_shifted;
    logic [OUT_W-1:0] raw;
    logic             np1, np2;
    logic             v1, v2, v3;
    logic             sat_s3;

    logic [OUT_W:0]   cur_ext;
    logic [OUT_W:0]   raw_ext;
    logic [OUT_W:0]   up_ext;
    logic [OUT_W:0]   dn_floor;
    logic [OUT_W-1:0] next_curr;

    // Incline is offset so a level road sits mid-range; steep descents zero the factor
    always_comb begin
        if (incline > INCL_HI) begin
            incline_sat = 10'b01_1111_1111;
        end else if (incline < INCL_LO) begin
            incline_sat = 10'b10_0000_0000;
        end else begin
            incline_sat = incline[9:0];
        end

        incline_sum = {incline_sat[9], incline_sat} + 11'd256;

        if (incline_sum[10]) begin
            incline_lim = 9'd0;
        end else if (incline_sum[9]) begin
            incline_lim = 9'h1FF;
        end else begin
            incline_lim = incline_sum[8:0];
        end
    end

    always_comb begin
        if (cadence > CAD_W'(1)) begin
            cadence_factor = {1'b0, cadence} + CAD_OFS;
        end else begin
            cadence_factor = '0;
        end

        if (avg_torque > TMIN) begin
            torque_pos = avg_torque - TMIN;
        end else begin
            torque_pos = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1  <= '0;
            p2  <= '0;
            np1 <= 1'b0;
            v1  <= 1'b0;
        end else begin
            p1  <= P1_W'(torque_pos) * P1_W'(scale);
            p2  <= P2_W'(incline_lim) * P2_W'(cadence_factor);
            np1 <= not_pedaling;
            v1  <= in_vld;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p3  <= '0;
            np2 <= 1'b0;
            v2  <= 1'b0;
        end else begin
            p3  <= P3_W'(p1) * P3_W'(p2);
            np2 <= np1;
            v2  <= v1;
        end
    end

    assign p3_shifted = p3 >> SHIFT;

    // Saturation is only reported when the sample actually drives current
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw    <= '0;
            sat_s3 <= 1'b0;
            v3     <= 1'b0;
        end else begin
            v3 <= v2;
            if (np2) begin
                raw    <= '0;
                sat_s3 <= 1'b0;
            end else if (p3_shifted > OUT_MAX) begin
                raw    <= '1;
                sat_s3 <= 1'b1;
            end else begin
                raw    <= p3_shifted[OUT_W-1:0];
                sat_s3 <= 1'b0;
            end
        end
    end

    // Comparisons are one bit wider so neither step can wrap past the target
    always_comb begin
        cur_ext  = {1'b0, target_curr};
        raw_ext  = {1'b0, raw};
        up_ext   = cur_ext + RISE_X;
        dn_floor = raw_ext + FALL_X;
        if (raw_ext > cur_ext) begin
            if (up_ext > raw_ext) begin
                next_curr = raw;
            end else begin
                next_curr = target_curr + OUT_W'(RISE_STEP);
            end
        end else if (raw_ext < cur_ext) begin
            if (cur_ext < dn_floor) begin
                next_curr = raw;
            end else begin
                next_curr = target_curr - OUT_W'(FALL_STEP);
            end
        end else begin
            next_curr = target_curr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_curr <= '0;
            out_vld     <= 1'b0;
            sat_flag    <= 1'b0;
        end else begin
            out_vld <= v3;
            if (v3) begin
                sat_flag <= sat_s3;
            end
            if (brake) begin
                target_curr <= '0;
            end else if (v3) begin
                target_curr <= next_curr;
            end
        end
    end

endmodule

// File: tb/tb_assist_curr_gen.sv
// Directed self-checking bench for assist_curr_gen: latency, ramp, decay,
// saturation, brake override and mid-pipeline reset.
module tb_assist_curr_gen;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_vld;
    logic [11:0]        avg_torque;
    logic [4:0]         cadence;
    logic               not_pedaling;
    logic signed [12:0] incline;
    logic [2:0]         scale;
    logic               brake;
    logic [11:0]        target_curr;
    logic               out_vld;
    logic               sat_flag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assist_curr_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_vld       (in_vld),
        .avg_torque   (avg_torque),
        .cadence      (cadence),
        .not_pedaling (not_pedaling),
        .incline      (incline),
        .scale        (scale),
        .brake        (brake),
        .target_curr  (target_curr),
        .out_vld      (out_vld),
        .sat_flag     (sat_flag)
    );

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task apply_reset;
        @(negedge clk);
        rst_n = 1'b0;
        in_vld = 1'b0;
        brake = 1'b0;
        not_pedaling = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task apply_idle;
        in_vld = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task apply_nominal;
        avg_torque = 12'h780;
        scale = 3'd3;
        incline = 13'sd0;
        cadence = 5'd16;
        not_pedaling = 1'b0;
    endtask

    task test_reset;
        rst_n = 1'b0;
        in_vld = 1'b0;
        brake = 1'b0;
        apply_nominal();
        #1;
        checks++;
        if (target_curr !== 12'd0) begin
            errors++;
            $display("[TB] FAIL reset_target: got %0d expected 0", target_curr);
        end
        checks++;
        if (out_vld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_vld: got %b expected 0", out_vld);
        end
        checks++;
        if (sat_flag !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_sat_flag: got %b expected 0", sat_flag);
        end
    endtask

    task test_single_sample;
        int c;
        apply_reset();
        apply_nominal();
        in_vld = 1'b1;
        @(negedge clk);
        in_vld = 1'b0;
        c = 1;
        while (out_vld !== 1'b1 && c < 10) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (out_vld !== 1'b1 || c != 4) begin
            errors++;
            $display("[TB] FAIL single_latency: got %0d cycles expected 4", c);
        end
        checks++;
        if (target_curr !== 12'd64) begin
            errors++;
            $display("[TB] FAIL single_target: got %0d expected 64", target_curr);
        end
        checks++;
        if (sat_flag !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_sat: got %b expected 0", sat_flag);
        end
        @(negedge clk);
        checks++;
        if (out_vld !== 1'b0 || target_curr !== 12'd64) begin
            errors++;
            $display("[TB] FAIL single_hold: got out_vld=%b target=%0d expected 0/64",
                     out_vld, target_curr);
        end
    endtask

    task test_back_to_back;
        int k, c, expv;
        apply_reset();
        apply_nominal();
        in_vld = 1'b1;
        k = 0;
        c = 0;
        while (k < 22 && c < 60) begin
            @(negedge clk);
            c++;
            if (out_vld === 1'b1) begin
                k++;
                expv = (k * 64 > 1152) ? 1152 : k * 64;
                checks++;
                if (target_curr !== 12'(expv)) begin
                    errors++;
                    $display("[TB] FAIL ramp_update_%0d: got %0d expected %0d",
                             k, target_curr, expv);
                end
            end
        end
        checks++;
        if (k != 22 || c != 25) begin
            errors++;
            $display("[TB] FAIL ramp_throughput: got %0d updates in %0d cycles expected 22 in 25",
                     k, c);
        end
        apply_idle();
    endtask

    task test_decay;
        int k, c, expv;
        checks++;
        if (target_curr !== 12'h480) begin
            errors++;
            $display("[TB] FAIL decay_start: got %0d expected 1152", target_curr);
        end
        not_pedaling = 1'b1;
        in_vld = 1'b1;
        k = 0;
        c = 0;
        while (k < 6 && c < 30) begin
            @(negedge clk);
            c++;
            if (out_vld === 1'b1) begin
                k++;
                expv = (1152 - 256 * k < 0) ? 0 : 1152 - 256 * k;
                checks++;
                if (target_curr !== 12'(expv)) begin
                    errors++;
                    $display("[TB] FAIL decay_update_%0d: got %0d expected %0d",
                             k, target_curr, expv);
                end
            end
        end
        checks++;
        if (k != 6) begin
            errors++;
            $display("[TB] FAIL decay_timeout: got %0d updates expected 6", k);
        end
        apply_idle();
        not_pedaling = 1'b0;
    endtask

    task test_saturation;
        int c;
        apply_reset();
        avg_torque = 12'hFFF;
        scale = 3'd7;
        incline = 13'sh0FFF;
        cadence = 5'd31;
        in_vld = 1'b1;
        @(negedge clk);
        in_vld = 1'b0;
        c = 1;
        while (out_vld !== 1'b1 && c < 10) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (out_vld !== 1'b1 || sat_flag !== 1'b1 || target_curr !== 12'd64) begin
            errors++;
            $display("[TB] FAIL sat_high: got out_vld=%b sat=%b target=%0d expected 1/1/64",
                     out_vld, sat_flag, target_curr);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (sat_flag !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sat_hold: got %b expected 1", sat_flag);
        end
        incline = 13'sh1000;
        in_vld = 1'b1;
        @(negedge clk);
        in_vld = 1'b0;
        c = 1;
        while (out_vld !== 1'b1 && c < 10) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (out_vld !== 1'b1 || sat_flag !== 1'b0 || target_curr !== 12'd0) begin
            errors++;
            $display("[TB] FAIL sat_neg_incline: got out_vld=%b sat=%b target=%0d expected 1/0/0",
                     out_vld, sat_flag, target_curr);
        end
        apply_idle();
    endtask

    task test_mid_values;
        int k, c;
        apply_reset();
        avg_torque = 12'h480;
        scale = 3'd5;
        incline = 13'sd100;
        cadence = 5'd2;
        not_pedaling = 1'b0;
        in_vld = 1'b1;
        k = 0;
        c = 0;
        while (k < 10 && c < 40) begin
            @(negedge clk);
            c++;
            if (out_vld === 1'b1) begin
                k++;
                if (k == 7 || k == 8 || k == 10) begin
                    checks++;
                    if (target_curr !== ((k == 7) ? 12'd448 : 12'd472)) begin
                        errors++;
                        $display("[TB] FAIL mid_up_%0d: got %0d expected %0d",
                                 k, target_curr, (k == 7) ? 448 : 472);
                    end
                end
            end
        end
        apply_idle();
        incline = -13'sd100;
        in_vld = 1'b1;
        k = 0;
        c = 0;
        while (k < 3 && c < 20) begin
            @(negedge clk);
            c++;
            if (out_vld === 1'b1) begin
                k++;
                checks++;
                if (target_curr !== ((k == 1) ? 12'd216 : 12'd207)) begin
                    errors++;
                    $display("[TB] FAIL mid_down_%0d: got %0d expected %0d",
                             k, target_curr, (k == 1) ? 216 : 207);
                end
            end
        end
        checks++;
        if (k != 3) begin
            errors++;
            $display("[TB] FAIL mid_timeout: got %0d updates expected 3", k);
        end
        apply_idle();
        cadence = 5'd1;
        in_vld = 1'b1;
        @(negedge clk);
        in_vld = 1'b0;
        c = 1;
        while (out_vld !== 1'b1 && c < 10) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (out_vld !== 1'b1 || target_curr !== 12'd0) begin
            errors++;
            $display("[TB] FAIL low_cadence: got out_vld=%b target=%0d expected 1/0",
                     out_vld, target_curr);
        end
        apply_idle();
    endtask

    task test_brake;
        int k, c;
        apply_reset();
        apply_nominal();
        in_vld = 1'b1;
        k = 0;
        c = 0;
        while (k < 5 && c < 30) begin
            @(negedge clk);
            c++;
            if (out_vld === 1'b1) k++;
        end
        checks++;
        if (target_curr !== 12'd320) begin
            errors++;
            $display("[TB] FAIL brake_pre: got %0d expected 320", target_curr);
        end
        brake = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            checks++;
            if (target_curr !== 12'd0 || out_vld !== 1'b1) begin
                errors++;
                $display("[TB] FAIL brake_hold_%0d: got target=%0d out_vld=%b expected 0/1",
                         j, target_curr, out_vld);
            end
        end
        brake = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            checks++;
            if (target_curr !== 12'(64 * j) || out_vld !== 1'b1) begin
                errors++;
                $display("[TB] FAIL brake_release_%0d: got target=%0d out_vld=%b expected %0d/1",
                         j, target_curr, out_vld, 64 * j);
            end
        end
        apply_idle();
    endtask

    task test_reset_mid;
        int c, seen;
        apply_reset();
        apply_nominal();
        in_vld = 1'b1;
        @(negedge clk);
        in_vld = 1'b0;
        apply_idle();
        checks++;
        if (target_curr !== 12'd64) begin
            errors++;
            $display("[TB] FAIL rstmid_pre: got %0d expected 64", target_curr);
        end
        in_vld = 1'b1;
        @(negedge clk);
        in_vld = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (target_curr !== 12'd0 || out_vld !== 1'b0 || sat_flag !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_async: got target=%0d out_vld=%b sat=%b expected 0/0/0",
                     target_curr, out_vld, sat_flag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_vld === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || target_curr !== 12'd0) begin
            errors++;
            $display("[TB] FAIL rstmid_discard: got %0d out_vld pulses target=%0d expected 0/0",
                     seen, target_curr);
        end
        in_vld = 1'b1;
        @(negedge clk);
        in_vld = 1'b0;
        c = 1;
        while (out_vld !== 1'b1 && c < 10) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (out_vld !== 1'b1 || c != 4 || target_curr !== 12'd64) begin
            errors++;
            $display("[TB] FAIL rstmid_first: got %0d cycles target=%0d expected 4/64",
                     c, target_curr);
        end
    endtask

    initial begin
        test_reset();
        test_single_sample();
        test_back_to_back();
        test_decay();
        test_saturation();
        test_mid_values();
        test_brake();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
